// File: rtl/cla_arbiter_ctrl_if.sv
// Request/response bundle between two issuing requesters and the shared-adder arbiter.
// The master side drives requests and consumes responses; the slave side is the arbiter.
interface cla_arbiter_ctrl_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_a;
    logic [DATA_WIDTH-1:0] req0_b;
    logic                  req0_sub;
    logic                  req0_cin;
    logic                  req0_chain;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_a;
    logic [DATA_WIDTH-1:0] req1_b;
    logic                  req1_sub;
    logic                  req1_cin;
    logic                  req1_chain;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_res;
    logic                  rsp_cout;
    logic                  rsp_gt;
    logic                  rsp_lt;
    logic                  rsp_eq;
    logic                  busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub, req0_cin, req0_chain,
        output req1_valid, req1_a, req1_b, req1_sub, req1_cin, req1_chain,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_res, rsp_cout, rsp_gt, rsp_lt, rsp_eq, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub, req0_cin, req0_chain,
        input  req1_valid, req1_a, req1_b, req1_sub, req1_cin, req1_chain,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_res, rsp_cout, rsp_gt, rsp_lt, rsp_eq, busy
    );
endinterface

// File: rtl/cla_arbiter_ctrl.sv
// Round-robin arbiter sharing one carry-lookahead adder between two requesters.
// Define CLA_CHAIN_EN to enable multi-word carry/borrow chaining with a requester lock.

module carry_lookahead #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_add_op,
    input  logic [DATA_WIDTH-1:0] i_op1,
    input  logic [DATA_WIDTH-1:0] i_op2,
    input  logic                  i_cin,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_cout
);
    // Operands are split into 4-bit lookahead groups; DATA_WIDTH must be a multiple of 4.
    localparam int NUM_GROUPS = DATA_WIDTH / 4;

    logic [DATA_WIDTH-1:0] w_op2;
    logic [DATA_WIDTH-1:0] w_g;
    logic [DATA_WIDTH-1:0] w_p;
    logic [DATA_WIDTH-1:0] w_c;
    logic [NUM_GROUPS:0]   w_gc;

    assign w_op2   = i_add_op ? i_op2 : ~i_op2;
    assign w_g     = i_op1 & w_op2;
    assign w_p     = i_op1 ^ w_op2;
    assign w_gc[0] = i_cin;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
            logic [3:0] w_gg;
            logic [3:0] w_pp;
            logic       w_ci;
            assign w_gg = w_g[4*gi +: 4];
            assign w_pp = w_p[4*gi +: 4];
            assign w_ci = w_gc[gi];

            assign w_c[4*gi]   = w_ci;
            assign w_c[4*gi+1] = w_gg[0] | (w_pp[0] & w_ci);
            assign w_c[4*gi+2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_ci);
            assign w_c[4*gi+3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                               | (w_pp[2] & w_pp[1] & w_pp[0] & w_ci);
            assign w_gc[gi+1]  = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                               | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0])
                               | (w_pp[3] & w_pp[2] & w_pp[1] & w_pp[0] & w_ci);
        end
    endgenerate

    assign o_res  = w_p ^ w_c;
    assign o_cout = w_gc[NUM_GROUPS];
endmodule

module cla_arbiter_ctrl #(
    parameter int DATA_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    cla_arbiter_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_rr_last;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_sub;
    logic                  r_id;
    logic                  r_cin_eff;
    logic [DATA_WIDTH-1:0] r_rsp_res;
    logic                  r_rsp_id;
    logic                  r_rsp_cout;
    logic                  r_rsp_gt;
    logic                  r_rsp_lt;
    logic                  r_rsp_eq;

    logic [1:0]            w_valid;
    logic                  w_grant_valid;
    logic                  w_grant_id;
    logic [DATA_WIDTH-1:0] w_sel_a;
    logic [DATA_WIDTH-1:0] w_sel_b;
    logic                  w_sel_sub;
    logic                  w_sel_cin;
    logic                  w_cin_eff;
    logic [DATA_WIDTH-1:0] w_op2;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_cout;

`ifdef CLA_CHAIN_EN
    logic r_chain;
    logic r_lock_valid;
    logic r_lock_id;
    logic r_chain_carry;
    logic w_sel_chain;
`else
    logic w_unused_chain;
    assign w_unused_chain = bus.req0_chain ^ bus.req1_chain;
`endif

    assign w_valid = {bus.req1_valid, bus.req0_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        case (r_state)
            ST_IDLE: begin
`ifdef CLA_CHAIN_EN
                if (r_lock_valid) begin
                    w_grant_valid = w_valid[r_lock_id];
                    w_grant_id    = r_lock_id;
                end else
`endif
                if (&w_valid) begin
                    w_grant_valid = 1'b1;
                    w_grant_id    = ~r_rr_last;
                end else if (w_valid[0]) begin
                    w_grant_valid = 1'b1;
                    w_grant_id    = 1'b0;
                end else if (w_valid[1]) begin
                    w_grant_valid = 1'b1;
                    w_grant_id    = 1'b1;
                end
                if (w_grant_valid) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    assign bus.req0_ready = rst_n & w_grant_valid & ~w_grant_id;
    assign bus.req1_ready = rst_n & w_grant_valid &  w_grant_id;

    assign w_sel_a   = w_grant_id ? bus.req1_a   : bus.req0_a;
    assign w_sel_b   = w_grant_id ? bus.req1_b   : bus.req0_b;
    assign w_sel_sub = w_grant_id ? bus.req1_sub : bus.req0_sub;
    assign w_sel_cin = w_grant_id ? bus.req1_cin : bus.req0_cin;

`ifdef CLA_CHAIN_EN
    assign w_sel_chain = w_grant_id ? bus.req1_chain : bus.req0_chain;
    // A continuing beat takes the previous beat's carry/borrow for both add and sub.
    assign w_cin_eff   = r_lock_valid ? r_chain_carry : (w_sel_sub | w_sel_cin);
`else
    assign w_cin_eff   = w_sel_sub | w_sel_cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last     <= 1'b1;
            r_a           <= '0;
            r_b           <= '0;
            r_sub         <= 1'b0;
            r_id          <= 1'b0;
            r_cin_eff     <= 1'b0;
            r_rsp_res     <= '0;
            r_rsp_id      <= 1'b0;
            r_rsp_cout    <= 1'b0;
            r_rsp_gt      <= 1'b0;
            r_rsp_lt      <= 1'b0;
            r_rsp_eq      <= 1'b0;
`ifdef CLA_CHAIN_EN
            r_chain       <= 1'b0;
            r_lock_valid  <= 1'b0;
            r_lock_id     <= 1'b0;
            r_chain_carry <= 1'b0;
`endif
        end else begin
            if (w_grant_valid) begin
                r_a       <= w_sel_a;
                r_b       <= w_sel_b;
                r_sub     <= w_sel_sub;
                r_id      <= w_grant_id;
                r_cin_eff <= w_cin_eff;
`ifdef CLA_CHAIN_EN
                r_chain   <= w_sel_chain;
                if (!r_lock_valid) begin
                    r_rr_last <= w_grant_id;
                end
`else
                r_rr_last <= w_grant_id;
`endif
            end
            if (r_state == ST_EXEC) begin
                r_rsp_res  <= w_sum;
                r_rsp_id   <= r_id;
                r_rsp_cout <= w_cout;
                r_rsp_gt   <= $signed(r_a) >  $signed(r_b);
                r_rsp_lt   <= $signed(r_a) <  $signed(r_b);
                r_rsp_eq   <= r_a == r_b;
`ifdef CLA_CHAIN_EN
                r_lock_valid  <= r_chain;
                r_lock_id     <= r_id;
                r_chain_carry <= r_chain & w_cout;
`endif
            end
        end
    end

    assign w_op2 = r_sub ? ~r_b : r_b;

    carry_lookahead #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cla (
        .i_add_op (1'b1),
        .i_op1    (r_a),
        .i_op2    (w_op2),
        .i_cin    (r_cin_eff),
        .o_res    (w_sum),
        .o_cout   (w_cout)
    );

    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.rsp_res   = r_rsp_res;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_cout  = r_rsp_cout;
    assign bus.rsp_gt    = r_rsp_gt;
    assign bus.rsp_lt    = r_rsp_lt;
    assign bus.rsp_eq    = r_rsp_eq;
endmodule

// File: tb/tb_cla_arbiter_ctrl.sv
// Directed bench for cla_arbiter_ctrl: arithmetic, latency, round-robin, stall and reset.
// The chaining scenario runs only when CLA_CHAIN_EN is defined.
module tb_cla_arbiter_ctrl;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cla_arbiter_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    cla_arbiter_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [63:0] a, input logic [63:0] b,
                           input logic sub, input logic cin, input logic chain, input logic valid);
        if (idx == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
            bus.req0_cin = cin; bus.req0_chain = chain; bus.req0_valid = valid;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
            bus.req1_cin = cin; bus.req1_chain = chain; bus.req1_valid = valid;
        end
    endtask

    task automatic clear_inputs();
        set_req(0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_req(1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at negedge+1 of the RESP cycle: check the full response, then accept it.
    task automatic check_rsp(input string tag, input logic [63:0] exp_res, input logic exp_cout,
                             input logic [2:0] exp_flags, input logic exp_id);
        check({tag, "_valid"}, bus.rsp_valid, 1'b1);
        check({tag, "_res"}, bus.rsp_res, exp_res);
        check({tag, "_cout"}, bus.rsp_cout, exp_cout);
        check({tag, "_gt_lt_eq"}, {bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}, exp_flags);
        check({tag, "_id"}, bus.rsp_id, exp_id);
        $display("txn %s: id=%0d res=%0h cout=%0d gt/lt/eq=%b", tag, bus.rsp_id, bus.rsp_res,
                 bus.rsp_cout, {bus.rsp_gt, bus.rsp_lt, bus.rsp_eq});
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input int idx, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic cin, input logic [63:0] exp_res,
                          input logic exp_cout, input logic [2:0] exp_flags);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        set_req(idx, a, b, sub, cin, 1'b0, 1'b1);
        #1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = (idx == 0) ? bus.req0_ready : bus.req1_ready;
            if (!ok) begin
                @(negedge clk);
                #1;
            end
        end
        check({tag, "_handshake"}, ok, 1'b1);
        if (ok) begin
            @(negedge clk);
            set_req(idx, a, b, sub, cin, 1'b0, 1'b0);
            #1;
            check({tag, "_exec_no_rsp"}, bus.rsp_valid, 1'b0);
            check({tag, "_exec_busy"}, bus.busy, 1'b1);
            @(negedge clk);
            #1;
            check_rsp(tag, exp_res, exp_cout, exp_flags, idx[0]);
            #1;
            check({tag, "_idle_after"}, bus.busy, 1'b0);
        end else begin
            set_req(idx, a, b, sub, cin, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int       grants[4];
        int       gc;
        int       rc;
        logic [63:0] exp_a;

        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_res", bus.rsp_res, 64'd0);
        check("reset_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        rst_n = 1'b1;

        run_op("add_7_5", 0, 64'd7, 64'd5, 1'b0, 1'b1, 64'd13, 1'b0, 3'b100);
        run_op("sub_3_9", 1, 64'd3, 64'd9, 1'b1, 1'b0, -64'sd6, 1'b0, 3'b010);
        run_op("sub_m1_m1", 1, '1, '1, 1'b1, 1'b1, 64'd0, 1'b1, 3'b001);
        exp_a = {1'b0, {63{1'b1}}};
        run_op("wrap_max_p1", 0, exp_a, 64'd1, 1'b0, 1'b0, {1'b1, 63'd0}, 1'b0, 3'b100);
        run_op("wrap_m1_p1", 0, '1, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 3'b010);

        // Round-robin with both requesters held valid; req0 wins first after reset.
        apply_reset();
        gc = 0;
        rc = 0;
        @(negedge clk);
        set_req(0, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        set_req(1, 64'd2, 64'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.rsp_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 60 && rc < 4; cyc++) begin
            if (bus.rsp_valid) begin
                check("rr_rsp_id", bus.rsp_id, grants[rc][0]);
                check("rr_rsp_res", bus.rsp_res, (grants[rc] == 1) ? 64'd4 : 64'd2);
                $display("txn rr%0d: id=%0d res=%0h", rc, bus.rsp_id, bus.rsp_res);
                rc++;
            end
            check("rr_not_both_ready", {1'b0, bus.req0_ready & bus.req1_ready}, 2'b00);
            if (gc < 4 && (bus.req0_ready || bus.req1_ready)) begin
                grants[gc] = bus.req1_ready ? 1 : 0;
                check("rr_grant_order", grants[gc], gc % 2);
                gc++;
            end
            @(negedge clk);
            if (gc == 4) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            #1;
        end
        check("rr_grant_count", gc, 4);
        check("rr_rsp_count", rc, 4);
        bus.rsp_ready = 1'b0;
        clear_inputs();

        // Response stall: outputs frozen and no acceptance while rsp_ready is low.
        @(negedge clk);
        set_req(0, 64'd10, 64'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        set_req(1, 64'd20, 64'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("stall_first_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("stall_rsp_valid", bus.rsp_valid, 1'b1);
        check("stall_rsp_res", bus.rsp_res, 64'd7);
        check("stall_rsp_id", bus.rsp_id, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("stall_hold_valid", bus.rsp_valid, 1'b1);
            check("stall_hold_res", bus.rsp_res, 64'd7);
            check("stall_hold_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
        end
        $display("txn stall: id=%0d res=%0h held 5 cycles", bus.rsp_id, bus.rsp_res);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        check("stall_next_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        #1;
        check_rsp("stall_second", 64'd21, 1'b0, 3'b100, 1'b1);

        // Reset in EXEC: everything drops at once, then req0 wins the tie again.
        @(negedge clk);
        set_req(0, 64'd4, 64'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        set_req(1, 64'd9, 64'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("rst_pre_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(negedge clk);
        #1;
        check("rst_in_exec", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", bus.rsp_valid, 1'b0);
        check("rst_async_busy", bus.busy, 1'b0);
        check("rst_async_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_tie_req0", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        #1;
        check_rsp("rst_after", 64'd8, 1'b0, 3'b001, 1'b0);

`ifdef CLA_CHAIN_EN
        // Two-beat chained add from req0 while req1 competes throughout.
        apply_reset();
        @(negedge clk);
        set_req(0, '1, 64'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        set_req(1, 64'd5, 64'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("chain_beat1_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(negedge clk);
        set_req(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check_rsp("chain_beat1", 64'd0, 1'b1, 3'b010, 1'b0);
        #1;
        check("chain_beat2_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        #1;
        check_rsp("chain_beat2", 64'd1, 1'b0, 3'b001, 1'b0);
        #1;
        check("chain_req1_after", {bus.req1_ready, bus.req0_ready}, 2'b10);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        #1;
        check_rsp("chain_req1", 64'd10, 1'b0, 3'b001, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
